// File: rtl/rfc_cell.sv
// rfc_cell: a single register-file storage cell.
// One DATA_W-bit word, written on the rising clock edge while write_en is high.
// The read port is a combinational AND-gate: data_out shows the stored word
// while read_en is high and all zeros otherwise.
// Optional build macro: RFC_BYPASS_EN adds a write-through bypass. When it is
// defined, a simultaneous read and write shows data_in on data_out before the
// capturing edge. Storage and reset behave the same in both builds.
module rfc_cell #(
  parameter int                 DATA_W    = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] r_storedWord;
  logic [DATA_W-1:0] w_readWord;

  // Storage word: reset forces RESET_VAL at once, and an enabled edge captures data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_storedWord <= RESET_VAL;
    end else if (write_en) begin
      r_storedWord <= data_in;
    end
  end

  // Select the word presented to the read gate; with bypass, a write in flight wins.
  always_comb begin
    w_readWord = r_storedWord;
`ifdef RFC_BYPASS_EN
    if (write_en) begin
      w_readWord = data_in;
    end
`else
    // Read-before-write: the old word stays visible until the capturing edge.
    w_readWord = r_storedWord;
`endif
  end

  assign data_out = read_en ? w_readWord : '0;

endmodule

// File: tb/tb_rfc_cell.sv
// tb_rfc_cell: self-checking bench for rfc_cell with a default 1-bit width.
// A behavioural model holds the word the cell should contain. The model
// applies the cell's rules at each rising edge, and the bench compares the
// output combinationally against it after every stimulus change.
module tb_rfc_cell;

  localparam int DATA_W = 1;
  localparam logic [DATA_W-1:0] RESET_VAL = '0;

  logic              clk;
  logic              rst_n;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  logic [DATA_W-1:0] modelWord;
  int checks;
  int errors;

  rfc_cell #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The expected read port value, derived from the current inputs and the model word.
  function automatic logic [DATA_W-1:0] expectedOut();
    logic [DATA_W-1:0] word;
    word = modelWord;
`ifdef RFC_BYPASS_EN
    if (write_en === 1'b1) word = data_in;
`endif
    return (read_en === 1'b1) ? word : '0;
  endfunction

  // Drive the inputs between clock edges, then let the combinational path settle.
  task automatic applyStimulus(input logic we, input logic re, input logic [DATA_W-1:0] din);
    write_en = we;
    read_en  = re;
    data_in  = din;
    #1;
  endtask

  // Drive the reset level. The model follows an asserted reset immediately.
  task automatic applyReset(input logic level);
    rst_n = level;
    if (!level) modelWord = RESET_VAL;
    #1;
  endtask

  // Advance one rising edge, updating the model from the inputs sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1 && write_en === 1'b1) modelWord = data_in;
    #1;
  endtask

  // Compare data_out against the model and count the result.
  task automatic checkOutput(input string tag);
    logic [DATA_W-1:0] exp;
    exp = expectedOut();
    checks++;
    assert (data_out === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, data_out, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelWord = RESET_VAL;
    write_en = 1'b0;
    read_en  = 1'b1;
    data_in  = '0;
    rst_n    = 1'b1;

    // Reset with the read enabled: the reset value appears without any clock edge.
    applyReset(1'b0);
    checkOutput("reset_read_on");
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("reset_read_off");
    applyReset(1'b1);

    // Basic write followed by a read.
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("basic_write_read");
    // Hold: further edges with write_en low keep the word.
    tick();
    checkOutput("hold_edge1");
    tick();
    checkOutput("hold_edge2");

    // Read gating toggles with zero cycle delay.
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gate_off");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("gate_on");

    // Random enables and data, checked before and after each edge.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    DATA_W'($urandom));
      checkOutput("rand_pre_edge");
      tick();
      checkOutput("rand_post_edge");
      read_en = 1'($urandom_range(0, 1));
      #1;
      checkOutput("rand_read_toggle");
    end

    // Simultaneous read and write with the word starting at 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("simul_rw_before_edge");
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("simul_rw_after_edge");

    // Asynchronous reset pulse in the middle of a write, between edges.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyReset(1'b0);
    checkOutput("async_reset_write_pending");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("async_reset_word");
    tick();
    checkOutput("async_reset_held");
    applyReset(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("write_after_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
